fetch_controller: RTL
=====================

Name: fetch_controller

Overview:
Sequences the combinational instruction memory for the 5-stage pipeline and owns the program counter. Each cycle it presents a word-aligned address to the instruction memory. It captures {pc, instr} into a 2-entry skid buffer and delivers it to the IF/ID stage over a valid/ready handshake. It also handles branch/jump redirects, pipeline flush, run enable and address faults.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
MEM_DEPTH, 256, instruction memory depth in words; legal PC range is 0 to MEM_DEPTH*4-4.
BUF_DEPTH, 2, skid buffer entries; fixed at 2, other values unsupported.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
fetch_en  in  1  when high, fetching is permitted (IDLE->RUN).
imem_addr  out  32  byte address to instruction memory; equals current pc.
imem_rdata  in  32  instruction word, combinationally valid in the same cycle as imem_addr.
redirect_valid  in  1  branch/jump taken from EX.
redirect_pc  in  32  redirect target.
out_valid  out  1  buffer head holds a valid instruction.
out_ready  in  1  IF/ID accepts the head this cycle.
out_instr  out  32  instruction at buffer head.
out_pc  out  32  PC of out_instr.
fault  out  1  sticky; set on a misaligned or out-of-range fetch address.
fault_pc  out  32  offending address captured when fault is set.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, buffer empty, count=0, state=IDLE, fault=0, fault_pc=0, out_valid=0, out_instr=0, out_pc=0.
- imem_addr = pc in all states; it is combinational from the pc register.
- FSM states: IDLE, RUN, FAULT.
  - IDLE: no push. Goes to RUN on the next edge when fetch_en=1.
  - RUN: goes to IDLE when fetch_en=0; no push occurs that cycle.
  - FAULT: terminal until rst.
- Push (RUN only): push=1 when state==RUN && fetch_en && !redirect_valid && pc legal && (count<2 || pop).
  - On push: entry={pc, imem_rdata} written at the tail, pc<=pc+4 (32-bit wrap, no carry out).
- Pop: pop = out_valid && out_ready. The head advances and count decrements.
  - Push and pop in the same cycle leave count unchanged. This is legal at count==2.
- out_valid = (count!=0). out_instr/out_pc come from head registers with no combinational path from imem_rdata.
  - Fetch-to-out_valid latency is 1 cycle: a push at edge N makes out_valid=1 after N.
- Back-pressure: with out_ready=0 the buffer fills to 2, push stops and pc holds. out_instr/out_pc stay stable while out_valid=1 && !out_ready.
- Redirect (priority over push and pop, any state except FAULT): on the edge, pc<=redirect_pc and the buffer is cleared (count=0); no push that cycle.
  - The first target instruction is pushed the next cycle, so out_valid rises 2 cycles after redirect_valid.
  - A redirect in IDLE updates pc only.
- Legality check applies to pc in RUN: pc[1:0]!=0 or pc>=MEM_DEPTH*4 -> on the next edge state=FAULT, fault=1, fault_pc=pc; no push.
  - Buffer contents remain and can still be popped.
  - A redirect in the same cycle as an illegal pc wins: pc takes the target and the check is re-evaluated next cycle.
- Reset mid-operation: all state returns to reset values immediately. Buffered entries are discarded and out_valid drops asynchronously.

Decomposition:
- Shared package rv_pipe_pkg:
  - typedef fetch_state_t {IDLE, RUN, FAULT}
  - typedef fetch_entry_t struct {pc[31:0], instr[31:0]}
  - constants INSTR_BYTES=4 and NOP_INSTR=32'h0000_0013
- One natural sub-module: fetch_skid_buffer, a 2-entry FIFO of fetch_entry_t with push, pop, clear, count, head. The controller holds the FSM, PC and fault logic.

Test Plan:
- Reset/startup: RESET_PC=0, memory[i]=i; rst high 3 cycles, fetch_en=1, out_ready=1 -> out_valid rises 1 cycle after first RUN cycle; sequence (pc,instr)=(0,0),(4,1),(8,2), one per cycle.
- Back-pressure: out_ready=0 for 5 cycles mid-stream -> count saturates at 2, pc holds at head+8, out_instr stable. Release -> no lost or duplicated instruction.
- Redirect: redirect_valid=1, redirect_pc=0x40 while 2 entries are buffered -> out_valid=0 next cycle, then (0x40,mem[16]), (0x44,mem[17]); the buffered entries are never delivered.
- Fault: redirect_pc=0x42 -> next cycle pc=0x42, following edge fault=1, fault_pc=0x42, no further pushes. Separately, with MEM_DEPTH=256, running to pc=0x400 -> fault_pc=0x400.
- Simultaneous redirect and pop at count==2 -> buffer cleared, pc=target, nothing pushed that cycle.
- Async reset asserted mid-stream between clock edges -> out_valid=0 and pc=RESET_PC without waiting for a clock edge.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared fetch-path types and constants for the 5-stage pipeline front end.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rv_pipe_pkg;

    // Fetch sequencer states; FAULT is only left through reset.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_controller_if.sv
// Groups the instruction-memory, redirect, IF/ID handshake and fault signals.
// Latency: n/a (wiring only).
// Backpressure: out_ready from IF/ID stalls delivery of out_* from the fetch buffer.
//
// master (fetch_controller): drives imem_addr, out_valid/out_instr/out_pc, fault/fault_pc;
//                            samples fetch_en, imem_rdata, redirect_valid/redirect_pc, out_ready.
// slave  (environment)     : the mirror image.
interface fetch_controller_if;

    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;

    modport master (
        input  fetch_en,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        input  out_ready,
        output imem_addr,
        output out_valid,
        output out_instr,
        output out_pc,
        output fault,
        output fault_pc
    );

    modport slave (
        output fetch_en,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        output out_ready,
        input  imem_addr,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  fault,
        input  fault_pc
    );

endinterface

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO of fetch entries with synchronous clear; head is driven from registers.
// Latency: a push is visible at head_o one cycle later (after the edge).
// Backpressure: push is accepted only when not full or when a pop happens in the same cycle.
//
// Ports: clk/rst; push_i + push_dat_i write at the tail; pop_i advances the head;
//        clear_i empties the buffer and wins over push/pop; count_o = occupancy; head_o = oldest entry.
module fetch_skid_buffer
    import rv_pipe_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_dat_i,
    input  logic         pop_i,
    input  logic         clear_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t entry_q [2];
    logic         head_q;
    logic         head_d;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         pop_ok;
    logic         push_ok;
    logic         tail_idx;

    always_comb begin
        pop_ok   = pop_i && (count_q != 2'd0);
        push_ok  = push_i && ((count_q != 2'd2) || pop_ok);
        // With two slots the tail is the head when count is 0 or 2, the other slot when 1.
        // At count 2 with a simultaneous pop the write lands in the slot being vacated.
        tail_idx = head_q ^ count_q[0];
        head_d   = head_q;
        count_d  = count_q;
        if (clear_i) begin
            head_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (pop_ok) begin
                head_d = ~head_q;
            end
            count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= 1'b0;
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
            if (push_ok && !clear_i) begin
                entry_q[tail_idx] <= push_dat_i;
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = entry_q[head_q];

endmodule

// File: rtl/fetch_controller.sv
// Owns the PC, sequences the combinational instruction memory and feeds IF/ID via a 2-entry buffer.
// Latency: a fetch at edge N shows out_valid after N; a redirect shows target data 2 cycles later.
// Backpressure: out_ready low fills the buffer to 2, then fetching stops and the PC holds.
//
// Ports: clk, rst (async, active high); bus (fetch_controller_if.master) carrying
//        fetch_en, imem_addr/imem_rdata, redirect_valid/redirect_pc,
//        out_valid/out_ready/out_instr/out_pc and the sticky fault/fault_pc.
module fetch_controller
    import rv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    fetch_controller_if.master        bus
);

    localparam logic [31:0] PC_LIMIT = 32'(MEM_DEPTH * INSTR_BYTES);
    localparam logic [1:0]  BUF_FULL = 2'(BUF_DEPTH);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic         fault_q;
    logic [31:0]  fault_pc_q;

    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_dat;
    logic         pc_legal;
    logic         pop;
    logic         push;
    logic         clear;

    always_comb begin
        pc_legal = (pc_q[1:0] == 2'b00) && (pc_q < PC_LIMIT);
        pop      = (count != 2'd0) && bus.out_ready;
        // Only a redirect while running discards wrong-path entries; in IDLE it just moves the PC.
        clear    = bus.redirect_valid && (state_q == RUN);
        push     = (state_q == RUN) && bus.fetch_en && !bus.redirect_valid && pc_legal
                   && ((count < BUF_FULL) || pop);
        push_dat = '{pc: pc_q, instr: bus.imem_rdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.redirect_valid) begin
                        pc_q <= bus.redirect_pc;
                    end
                    if (bus.fetch_en) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Redirect outranks the legality check so a bad PC can be steered away.
                    if (bus.redirect_valid) begin
                        pc_q <= bus.redirect_pc;
                        if (!bus.fetch_en) begin
                            state_q <= IDLE;
                        end
                    end else if (!bus.fetch_en) begin
                        state_q <= IDLE;
                    end else if (!pc_legal) begin
                        state_q    <= FAULT;
                        fault_q    <= 1'b1;
                        fault_pc_q <= pc_q;
                    end else if (push) begin
                        pc_q <= pc_q + 32'(INSTR_BYTES);
                    end
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    fetch_skid_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .clear_i    (clear),
        .count_o    (count),
        .head_o     (head)
    );

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;
    assign bus.fault     = fault_q;
    assign bus.fault_pc  = fault_pc_q;

endmodule
